// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU sharing controller.
package alu_share_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int NUM_REQ = 2;
   localparam int ID_W    = 1;
   localparam int SEL_W   = 4;

endpackage

// File: rtl/ALU.sv
// Combinational ALU shared by the controller; result is truncated to n bits.
module ALU #(
   parameter int n = 8
) (
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   input  logic [3:0]   sel,
   output logic [n-1:0] out
);

   // Operation decode; unused select codes yield zero
   always_comb begin
      out = {n{1'b0}};
      case (sel)
         4'd0:    out = A + B;
         4'd1:    out = A - B;
         4'd2:    out = A & B;
         4'd3:    out = A | B;
         4'd4:    out = A ^ B;
         4'd5:    out = ~A;
         4'd6:    out = A << 1;
         4'd7:    out = A >> 1;
         4'd8:    out = A;
         4'd9:    out = B;
         4'd10:   out = A + {{(n-1){1'b0}}, 1'b1};
         4'd11:   out = A - {{(n-1){1'b0}}, 1'b1};
         default: out = {n{1'b0}};
      endcase
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between two valid/ready requesters,
// one operation in flight, with a shared result accumulator.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int n = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   input  logic [n-1:0]       req_a0,
   input  logic [n-1:0]       req_b0,
   input  logic [SEL_W-1:0]   req_sel0,
   input  logic               req_acc0,
   input  logic [n-1:0]       req_a1,
   input  logic [n-1:0]       req_b1,
   input  logic [SEL_W-1:0]   req_sel1,
   input  logic               req_acc1,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [n-1:0]       rsp_data,
   output logic [ID_W-1:0]    rsp_id,
   output logic               busy
);

   state_t            state_r;
   logic [ID_W-1:0]   rr_ptr_r;
   logic [n-1:0]      acc_r;
   logic [n-1:0]      op_a_r;
   logic [n-1:0]      op_b_r;
   logic [SEL_W-1:0]  op_sel_r;
   logic [ID_W-1:0]   op_id_r;
   logic [n-1:0]      rsp_data_r;
   logic              rsp_valid_r;
   logic              busy_r;

   logic [ID_W-1:0]    grant_s;
   logic [NUM_REQ-1:0] req_ready_s;
   logic               accept_s;
   logic [n-1:0]       nxt_a_s;
   logic [n-1:0]       nxt_b_s;
   logic [SEL_W-1:0]   nxt_sel_s;
   logic [n-1:0]       alu_out_s;

   // Arbitration: a lone requester wins, otherwise rr_ptr decides
   always_comb begin
      grant_s     = 1'b0;
      req_ready_s = 2'b00;
      if (req_valid == 2'b11) begin
         grant_s = rr_ptr_r;
      end else if (req_valid == 2'b10) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
      if (rst_n && (state_r == S_IDLE) && (req_valid != 2'b00)) begin
         req_ready_s[grant_s] = 1'b1;
      end else begin
         req_ready_s = 2'b00;
      end
   end

   assign accept_s = |(req_valid & req_ready_s);

   // Operand selection for the granted requester
   always_comb begin
      if (grant_s == 1'b1) begin
         nxt_a_s   = req_acc1 ? acc_r : req_a1;
         nxt_b_s   = req_b1;
         nxt_sel_s = req_sel1;
      end else begin
         nxt_a_s   = req_acc0 ? acc_r : req_a0;
         nxt_b_s   = req_b0;
         nxt_sel_s = req_sel0;
      end
   end

   ALU #(.n(n)) u_alu (
      .A   (op_a_r),
      .B   (op_b_r),
      .sel (op_sel_r),
      .out (alu_out_s)
   );

   // Controller FSM with registered operands, result and status
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         rr_ptr_r    <= 1'b0;
         acc_r       <= {n{1'b0}};
         op_a_r      <= {n{1'b0}};
         op_b_r      <= {n{1'b0}};
         op_sel_r    <= 4'd0;
         op_id_r     <= 1'b0;
         rsp_data_r  <= {n{1'b0}};
         rsp_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  op_a_r   <= nxt_a_s;
                  op_b_r   <= nxt_b_s;
                  op_sel_r <= nxt_sel_s;
                  op_id_r  <= grant_s;
                  rr_ptr_r <= ~grant_s;
                  busy_r   <= 1'b1;
                  state_r  <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_data_r  <= alu_out_s;
               acc_r       <= alu_out_s;
               rsp_valid_r <= 1'b1;
               state_r     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = req_ready_s;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_id    = op_id_r;
   assign busy      = busy_r;

endmodule
